// File: rtl/damage_display.sv
// damage_display: converts a 7-bit damage percentage (0..100, larger values
// clamped to 100) to BCD with a sequential double-dabble engine, then drives a
// time-multiplexed, active-low 3-digit 7-segment display with leading-zero
// blanking.
// Optional feature macro: DAMAGE_DISPLAY_BLINK_EN
//   Defined: the display blinks while the shown value exceeds BLINK_THRESH.
//   Undefined: the display is always on and BLINK_DIV/BLINK_THRESH are unused.
// Ports:
//   clk    - main clock
//   reset  - synchronous, active-high reset
//   damage - binary damage percentage
//   seg    - segments {g,f,e,d,c,b,a}, active-low, registered
//   an     - digit enables, active-low (an[0]=ones, an[1]=tens, an[2]=hundreds)
//   busy   - high while a conversion is in progress
module damage_display #(
  parameter int unsigned SCAN_DIV     = 10000,
  parameter int unsigned BLINK_DIV    = 8325000,
  parameter int unsigned BLINK_THRESH = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] damage,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam int unsigned DW      = 7;
  localparam int unsigned BCD_W   = 10;
  localparam int unsigned SCAN_W  = 24;
  localparam int unsigned BLINK_W = 24;
  localparam int unsigned ITER    = 7;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic              start_c;
  logic [DW-1:0]     dmg_clamp;
  logic [DW-1:0]     bin;
  logic [BCD_W-1:0]  bcd;
  logic [7:0]        bcd_adj;
  logic [2:0]        cnt;
  logic [DW-1:0]     conv_val;
  logic [DW-1:0]     last_val;
  logic              last_valid;
  logic [3:0]        hund;
  logic [3:0]        tens;
  logic [3:0]        ones;
  logic [SCAN_W-1:0] prescale;
  logic [1:0]        idx;
  logic [3:0]        digit;
  logic              blank;
  logic              blink_blank_c;
  logic [6:0]        seg_next;
  logic [2:0]        an_next;

  // Active-low gfedcba encoding of one decimal digit.
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'b1111111;
    endcase
  endfunction

  assign dmg_clamp = (damage > DW'(100)) ? DW'(100) : damage;

  // Add-3 correction; hundreds never exceeds 1 so it needs no correction.
  assign bcd_adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
  assign bcd_adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    case (state)
      IDLE: begin
        if (!last_valid || (dmg_clamp != last_val)) begin
          start_c    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 3'(ITER - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath and atomic display-register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      conv_val   <= '0;
      last_val   <= '0;
      last_valid <= 1'b0;
      hund       <= '0;
      tens       <= '0;
      ones       <= '0;
      busy       <= 1'b0;
    end else begin
      if (start_c) begin
        bin      <= dmg_clamp;
        conv_val <= dmg_clamp;
        bcd      <= '0;
        cnt      <= '0;
        busy     <= 1'b1;
      end
      if (state == SHIFT) begin
        bcd <= {bcd[8], bcd_adj, bin[DW-1]};
        bin <= {bin[DW-2:0], 1'b0};
        cnt <= cnt + 3'd1;
      end
      if (state == DONE) begin
        hund       <= {2'b00, bcd[9:8]};
        tens       <= bcd[7:4];
        ones       <= bcd[3:0];
        last_val   <= conv_val;
        last_valid <= 1'b1;
        busy       <= 1'b0;
      end
    end
  end

`ifdef DAMAGE_DISPLAY_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  // Blink phase generator; phase starts in the "on" half.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // last_val always equals the value held in the display registers.
  assign blink_blank_c = !phase && (last_val > DW'(BLINK_THRESH));
`else
  // Display is always on in this build.
  assign blink_blank_c = 1'b0 && (BLINK_DIV != 0) && (BLINK_THRESH != 0);
`endif

  // Digit selection with leading-zero blanking.
  always_comb begin
    digit = ones;
    blank = 1'b0;
    case (idx)
      2'd1: begin
        digit = tens;
        blank = (hund == 4'd0) && (tens == 4'd0);
      end
      2'd2: begin
        digit = hund;
        blank = (hund == 4'd0);
      end
      default: ;
    endcase
    seg_next = blank ? 7'b1111111 : seg_enc(digit);
    an_next  = ~(3'b001 << idx);
    if (blink_blank_c) begin
      seg_next = 7'b1111111;
      an_next  = 3'b111;
    end
  end

  // Scan prescaler, digit index and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      idx      <= '0;
      seg      <= 7'b1111111;
      an       <= 3'b111;
    end else begin
      if (prescale == SCAN_W'(SCAN_DIV - 1)) begin
        prescale <= '0;
        idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        prescale <= prescale + SCAN_W'(1);
      end
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule
